adder_n: RTL and testbench

- Parameterised N-bit binary adder with carry-in and carry-out; the combinational sum path has zero latency.
- Used wherever a full-width sum plus carry is needed, e.g. an averaging unit takes {c_out, s} as an (N+1)-bit sum and drops the LSB.
- Also provides a registered copy of the result (sum, carry, signed overflow) for pipelined consumers.

---
 rtl/adder_n_pkg.sv | 24 ++
 rtl/adder_n_if.sv | 25 ++
 rtl/adder_n_full_adder_cell.sv | 16 +
 rtl/adder_n.sv | 57 +++++
 tb/tb_adder_n.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/adder_n_pkg.sv
// Shared types and bit-level helpers for the adder_n ripple-carry adder.
// Holds the legal width range and the full-adder cell equation.
package adder_n_pkg;

    localparam int unsigned N_MIN = 1;
    localparam int unsigned N_MAX = 64;

    typedef struct packed {
        logic s;
        logic co;
    } fa_out_t;

    function automatic fa_out_t fa_bit(
        input logic a,
        input logic b,
        input logic ci
    );
        fa_out_t r;
        r.s  = a ^ b ^ ci;
        r.co = (a & b) | (ci & (a ^ b));
        return r;
    endfunction

endpackage

// File: rtl/adder_n_if.sv
// Operand/result bundle for adder_n: operands in, combinational and
// registered results out.
interface adder_n_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         c_in;
    logic [N-1:0] s;
    logic         c_out;
    logic         ovf;
    logic [N-1:0] s_r;
    logic         c_out_r;
    logic         ovf_r;

    modport master (
        output x, y, c_in,
        input  s, c_out, ovf, s_r, c_out_r, ovf_r
    );

    modport slave (
        input  x, y, c_in,
        output s, c_out, ovf, s_r, c_out_r, ovf_r
    );
endinterface

// File: rtl/adder_n_full_adder_cell.sv
// One bit of the ripple-carry chain in adder_n.
module full_adder_cell
    import adder_n_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    fa_out_t w_r;

    assign w_r = fa_bit(a, b, ci);
    assign s   = w_r.s;
    assign co  = w_r.co;
endmodule

// File: rtl/adder_n.sv
// N-bit ripple-carry adder with zero-latency sum/carry/overflow
// plus a one-cycle registered copy cleared by async reset.
module adder_n
    import adder_n_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic      clock,
    input  logic      reset_,
    adder_n_if.slave  bus
);
    if (N < N_MIN || N > N_MAX) begin : g_bad_width
        $error("adder_n: N out of range");
    end

    logic [N:0]   w_c;
    logic [N-1:0] w_s;
    logic         w_ovf;

    logic [N-1:0] r_s;
    logic         r_c_out;
    logic         r_ovf;

    assign w_c[0] = bus.c_in;

    for (genvar i = 0; i < N; i++) begin : g_cell
        full_adder_cell u_fa (
            .a  (bus.x[i]),
            .b  (bus.y[i]),
            .ci (w_c[i]),
            .s  (w_s[i]),
            .co (w_c[i+1])
        );
    end

    // For N=1, w_c[N-1] is c_in, so this also covers the 1-bit case.
    assign w_ovf = w_c[N] ^ w_c[N-1];

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_s     <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_s     <= w_s;
            r_c_out <= w_c[N];
            r_ovf   <= w_ovf;
        end
    end

    assign bus.s       = w_s;
    assign bus.c_out   = w_c[N];
    assign bus.ovf     = w_ovf;
    assign bus.s_r     = r_s;
    assign bus.c_out_r = r_c_out;
    assign bus.ovf_r   = r_ovf;
endmodule

// File: tb/tb_adder_n.sv
// Scoreboard bench for adder_n at N=8 (directed + reset), N=4
// (exhaustive), N=1 and N=16 (spot checks).
module tb_adder_n;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    adder_n_if #(.N(8))  if8 ();
    adder_n_if #(.N(4))  if4 ();
    adder_n_if #(.N(1))  if1 ();
    adder_n_if #(.N(16)) if16 ();

    adder_n #(.N(8)) u8 (
        .clock(clk), .reset_(rst_n), .bus(if8.slave)
    );
    adder_n #(.N(4)) u4 (
        .clock(clk), .reset_(rst_n), .bus(if4.slave)
    );
    adder_n #(.N(1)) u1 (
        .clock(clk), .reset_(rst_n), .bus(if1.slave)
    );
    adder_n #(.N(16)) u16 (
        .clock(clk), .reset_(rst_n), .bus(if16.slave)
    );

    typedef struct {
        string       tag;
        int unsigned dut;
        logic [63:0] s;
        logic        c;
        logic        v;
        bit          chk_reg;
        logic [63:0] sr;
        logic        cr;
        logic        vr;
        bit          chk_avg;
        logic [63:0] avg;
    } exp_t;

    exp_t sb[$];
    int checks;
    int passes;

    task automatic chk(input string tag, input string what,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s.%s: got %0h want %0h",
                     tag, what, act, exp);
        else
            passes++;
    endtask

    exp_t        m_e;
    logic [63:0] a_s, a_sr;
    logic        a_c, a_v, a_cr, a_vr;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            m_e = sb.pop_front();
            case (m_e.dut)
                1: begin
                    a_s = 64'(if1.s); a_c = if1.c_out;
                    a_v = if1.ovf; a_sr = 64'(if1.s_r);
                    a_cr = if1.c_out_r; a_vr = if1.ovf_r;
                end
                4: begin
                    a_s = 64'(if4.s); a_c = if4.c_out;
                    a_v = if4.ovf; a_sr = 64'(if4.s_r);
                    a_cr = if4.c_out_r; a_vr = if4.ovf_r;
                end
                16: begin
                    a_s = 64'(if16.s); a_c = if16.c_out;
                    a_v = if16.ovf; a_sr = 64'(if16.s_r);
                    a_cr = if16.c_out_r; a_vr = if16.ovf_r;
                end
                default: begin
                    a_s = 64'(if8.s); a_c = if8.c_out;
                    a_v = if8.ovf; a_sr = 64'(if8.s_r);
                    a_cr = if8.c_out_r; a_vr = if8.ovf_r;
                end
            endcase
            chk(m_e.tag, "s", a_s, m_e.s);
            chk(m_e.tag, "c_out", 64'(a_c), 64'(m_e.c));
            chk(m_e.tag, "ovf", 64'(a_v), 64'(m_e.v));
            if (m_e.chk_reg) begin
                chk(m_e.tag, "s_r", a_sr, m_e.sr);
                chk(m_e.tag, "c_out_r", 64'(a_cr), 64'(m_e.cr));
                chk(m_e.tag, "ovf_r", 64'(a_vr), 64'(m_e.vr));
            end
            if (m_e.chk_avg)
                chk(m_e.tag, "avg", {a_c, a_s[7:0]} >> 1, m_e.avg);
        end
    end

    // Bench model of the registered copy for the N=8 instance.
    logic [9:0] prev8;
    logic [9:0] mreg8;

    task automatic step8(input string tag, input logic rst_val,
                         input logic [7:0] x, input logic [7:0] y,
                         input logic ci, input logic [7:0] es,
                         input logic ec, input logic ev,
                         input bit do_avg, input logic [63:0] avg);
        logic edge_rst;
        exp_t e;
        @(posedge clk);
        edge_rst = rst_n;
        #1;
        mreg8 = edge_rst ? prev8 : 10'd0;
        rst_n = rst_val;
        if (!rst_val) mreg8 = 10'd0;
        if8.x = x; if8.y = y; if8.c_in = ci;
        e.tag = tag; e.dut = 8;
        e.s = 64'(es); e.c = ec; e.v = ev;
        e.chk_reg = 1'b1;
        e.sr = 64'(mreg8[7:0]);
        e.cr = mreg8[8]; e.vr = mreg8[9];
        e.chk_avg = do_avg; e.avg = avg;
        sb.push_back(e);
        prev8 = {ev, ec, es};
    endtask

    task automatic push_comb(input string tag, input int unsigned dut,
                             input logic [63:0] es, input logic ec,
                             input logic ev);
        exp_t e;
        e.tag = tag; e.dut = dut;
        e.s = es; e.c = ec; e.v = ev;
        e.chk_reg = 1'b0; e.sr = '0; e.cr = 1'b0; e.vr = 1'b0;
        e.chk_avg = 1'b0; e.avg = '0;
        sb.push_back(e);
    endtask

    task automatic step16(input string tag, input logic [15:0] x,
                          input logic [15:0] y, input logic ci,
                          input logic [15:0] es, input logic ec,
                          input logic ev);
        @(posedge clk);
        #1;
        if16.x = x; if16.y = y; if16.c_in = ci;
        push_comb(tag, 16, 64'(es), ec, ev);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        prev8 = '0;
        mreg8 = '0;
        rst_n = 1'b0;
        if8.x = '0;  if8.y = '0;  if8.c_in = 1'b0;
        if4.x = '0;  if4.y = '0;  if4.c_in = 1'b0;
        if1.x = '0;  if1.y = '0;  if1.c_in = 1'b0;
        if16.x = '0; if16.y = '0; if16.c_in = 1'b0;

        step8("reset_state", 1'b0, 8'd0, 8'd0, 1'b0,
              8'd0, 1'b0, 1'b0, 1'b0, 64'd0);
        step8("200+100", 1'b1, 8'd200, 8'd100, 1'b0,
              8'd44, 1'b1, 1'b0, 1'b1, 64'd150);
        step8("255+0+1", 1'b1, 8'd255, 8'd0, 1'b1,
              8'd0, 1'b1, 1'b0, 1'b0, 64'd0);
        step8("0+0+0", 1'b1, 8'd0, 8'd0, 1'b0,
              8'd0, 1'b0, 1'b0, 1'b0, 64'd0);
        step8("127+1", 1'b1, 8'd127, 8'd1, 1'b0,
              8'd128, 1'b0, 1'b1, 1'b0, 64'd0);
        step8("128+128", 1'b1, 8'd128, 8'd128, 1'b0,
              8'd0, 1'b1, 1'b1, 1'b0, 64'd0);
        step8("255+255+1", 1'b1, 8'd255, 8'd255, 1'b1,
              8'd255, 1'b1, 1'b0, 1'b0, 64'd0);
        step8("10+20", 1'b1, 8'd10, 8'd20, 1'b0,
              8'd30, 1'b0, 1'b0, 1'b0, 64'd0);
        step8("hold30", 1'b1, 8'd10, 8'd20, 1'b0,
              8'd30, 1'b0, 1'b0, 1'b0, 64'd0);
        step8("rst_mid", 1'b0, 8'd10, 8'd20, 1'b0,
              8'd30, 1'b0, 1'b0, 1'b0, 64'd0);
        step8("rst_hold", 1'b0, 8'd10, 8'd20, 1'b0,
              8'd30, 1'b0, 1'b0, 1'b0, 64'd0);
        step8("rst_rel", 1'b1, 8'd10, 8'd20, 1'b0,
              8'd30, 1'b0, 1'b0, 1'b0, 64'd0);
        step8("post_rel", 1'b1, 8'd10, 8'd20, 1'b0,
              8'd30, 1'b0, 1'b0, 1'b0, 64'd0);

        for (int xi = 0; xi < 16; xi++)
            for (int yi = 0; yi < 16; yi++)
                for (int ci = 0; ci < 2; ci++) begin
                    logic [4:0] sum;
                    logic [3:0] xv, yv;
                    logic       ov;
                    xv = 4'(xi); yv = 4'(yi);
                    sum = 5'(xi + yi + ci);
                    ov = (xv[3] == yv[3]) && (sum[3] != xv[3]);
                    @(posedge clk);
                    #1;
                    if4.x = xv; if4.y = yv; if4.c_in = 1'(ci);
                    push_comb($sformatf("n4_%0d_%0d_%0d", xi, yi, ci),
                              4, 64'(sum[3:0]), sum[4], ov);
                end

        for (int k = 0; k < 8; k++) begin
            logic [2:0] kv;
            logic [1:0] sum;
            logic       ov;
            kv = 3'(k);
            sum = 2'(kv[0] + kv[1] + kv[2]);
            ov = (kv[0] == kv[1]) && (sum[0] != kv[0]);
            @(posedge clk);
            #1;
            if1.x = kv[0]; if1.y = kv[1]; if1.c_in = kv[2];
            push_comb($sformatf("n1_%0d", k), 1,
                      64'(sum[0]), sum[1], ov);
        end

        step16("n16_wrap", 16'hFFFF, 16'h0000, 1'b1,
               16'h0000, 1'b1, 1'b0);
        step16("n16_ovf", 16'h7FFF, 16'h0001, 1'b0,
               16'h8000, 1'b0, 1'b1);
        step16("n16_negovf", 16'h8000, 16'h8000, 1'b0,
               16'h0000, 1'b1, 1'b1);
        step16("n16_mix", 16'h1234, 16'h4321, 1'b1,
               16'h5556, 1'b0, 1'b0);
        step16("n16_max", 16'hFFFF, 16'hFFFF, 1'b1,
               16'hFFFF, 1'b1, 1'b0);

        @(negedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d left want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
